// File: rtl/lbist_pkg.sv
// Shared definitions for the logic-BIST controller and the LFSR/MISR benches.
//   lbist_state_e      : controller sequencing states
//   DEFAULT_SEEDS      : default 4 x 32-bit seed table, seed i at [i*32 +: 32]
//   DEFAULT_SIGNATURES : default 4 x 32-bit golden signatures, same slicing
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } lbist_state_e;

  localparam logic [4*32-1:0] DEFAULT_SEEDS = {
    32'h0BAD_F00D, 32'hC0FF_EE00, 32'hDEAD_BEEF, 32'h1234_5678
  };

  localparam logic [4*32-1:0] DEFAULT_SIGNATURES = {
    32'h8E1F_04A7, 32'h3C5A_9D12, 32'h7B24_E6C0, 32'hA5A5_5A5A
  };

endpackage

// File: rtl/lbist_controller_if.sv
// Handshake bundle around the BIST controller.
//   lbist_req/lbist_resp : requester starts a run and collects per-seed pass bits
//   lfsr_resp            : seed delivered to the LFSR pattern generator
//   misr_req             : number of CUT outputs the MISR should hash
//   misr_resp            : signature returned by the MISR
// modport master is the controller side, slave is the surrounding environment.
interface lbist_controller_if #(
  parameter int NUM_SEEDS      = 4,
  parameter int SEED_BITS      = 32,
  parameter int SIGNATURE_BITS = 32,
  parameter int LBIST_MSG_BITS = 5
);

  logic                      lbist_req_val;
  logic                      lbist_req_rdy;
  logic                      lbist_resp_val;
  logic [NUM_SEEDS-1:0]      lbist_resp_msg;
  logic                      lbist_resp_rdy;

  logic                      lfsr_resp_val;
  logic [SEED_BITS-1:0]      lfsr_resp_msg;
  logic                      lfsr_resp_rdy;

  logic                      misr_req_val;
  logic [LBIST_MSG_BITS:0]   misr_req_msg;
  logic                      misr_req_rdy;

  logic                      misr_resp_val;
  logic [SIGNATURE_BITS-1:0] misr_resp_msg;
  logic                      misr_resp_rdy;

  modport master (
    input  lbist_req_val,
    output lbist_req_rdy,
    output lbist_resp_val,
    output lbist_resp_msg,
    input  lbist_resp_rdy,
    output lfsr_resp_val,
    output lfsr_resp_msg,
    input  lfsr_resp_rdy,
    output misr_req_val,
    output misr_req_msg,
    input  misr_req_rdy,
    input  misr_resp_val,
    input  misr_resp_msg,
    output misr_resp_rdy
  );

  modport slave (
    output lbist_req_val,
    input  lbist_req_rdy,
    input  lbist_resp_val,
    input  lbist_resp_msg,
    output lbist_resp_rdy,
    input  lfsr_resp_val,
    input  lfsr_resp_msg,
    output lfsr_resp_rdy,
    input  misr_req_val,
    input  misr_req_msg,
    output misr_req_rdy,
    output misr_resp_val,
    output misr_resp_msg,
    input  misr_resp_rdy
  );

endinterface

// File: rtl/lbist_controller.sv
// Logic-BIST run sequencer. For each seed: hand the seed to the LFSR and the
// hash count to the MISR (independently, possibly in the same cycle), wait for
// the signature, and record whether it matches the golden value. After the last
// seed, the per-seed pass vector is offered to the requester.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   io         : handshake bundle (lbist_req/resp, lfsr_resp, misr_req/resp)
// All outputs are registered.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int SEED_BITS           = 32,
  parameter int SIGNATURE_BITS      = 32,
  parameter int NUM_SEEDS           = 4,
  parameter int NUM_HASHES          = 16,
  parameter int MAX_OUTPUTS_TO_HASH = 32,
  parameter int LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH),
  parameter logic [NUM_SEEDS*SEED_BITS-1:0]      SEEDS      = DEFAULT_SEEDS,
  parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] SIGNATURES = DEFAULT_SIGNATURES
) (
  input  logic               clk,
  input  logic               reset,
  lbist_controller_if.master io
);

  localparam int IDX_BITS = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
  localparam logic [IDX_BITS-1:0]       LAST_IDX   = IDX_BITS'(NUM_SEEDS - 1);
  localparam logic [LBIST_MSG_BITS:0]   HASH_COUNT = (LBIST_MSG_BITS + 1)'(NUM_HASHES);

  lbist_state_e         state;
  logic [IDX_BITS-1:0]  seed_idx;
  logic [IDX_BITS-1:0]  next_idx;
  logic                 lfsr_sent;
  logic                 misr_sent;
  logic [NUM_SEEDS-1:0] result;
  logic [NUM_SEEDS-1:0] result_upd;

  logic lbist_req_xfer;
  logic lbist_resp_xfer;
  logic lfsr_xfer;
  logic misr_req_xfer;
  logic misr_resp_xfer;
  logic lfsr_done;
  logic misr_done;
  logic sig_match;

  function automatic logic [SEED_BITS-1:0] seed_at(input logic [IDX_BITS-1:0] idx);
    return SEEDS[int'(idx)*SEED_BITS +: SEED_BITS];
  endfunction

  function automatic logic [SIGNATURE_BITS-1:0] golden_at(input logic [IDX_BITS-1:0] idx);
    return SIGNATURES[int'(idx)*SIGNATURE_BITS +: SIGNATURE_BITS];
  endfunction

  always_comb begin
    lbist_req_xfer  = io.lbist_req_val  && io.lbist_req_rdy;
    lbist_resp_xfer = io.lbist_resp_val && io.lbist_resp_rdy;
    lfsr_xfer       = io.lfsr_resp_val  && io.lfsr_resp_rdy;
    misr_req_xfer   = io.misr_req_val   && io.misr_req_rdy;
    misr_resp_xfer  = io.misr_resp_val  && io.misr_resp_rdy;
    // A channel counts as done if it finished earlier or is finishing now.
    lfsr_done       = lfsr_sent || lfsr_xfer;
    misr_done       = misr_sent || misr_req_xfer;
    next_idx        = seed_idx + 1'b1;
    sig_match       = (io.misr_resp_msg == golden_at(seed_idx));
    result_upd           = result;
    result_upd[seed_idx] = sig_match;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      seed_idx          <= '0;
      lfsr_sent         <= 1'b0;
      misr_sent         <= 1'b0;
      result            <= '0;
      io.lbist_req_rdy  <= 1'b1;
      io.lbist_resp_val <= 1'b0;
      io.lbist_resp_msg <= '0;
      io.lfsr_resp_val  <= 1'b0;
      io.lfsr_resp_msg  <= '0;
      io.misr_req_val   <= 1'b0;
      io.misr_req_msg   <= '0;
      io.misr_resp_rdy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lbist_req_xfer) begin
            state            <= SEND;
            seed_idx         <= '0;
            lfsr_sent        <= 1'b0;
            misr_sent        <= 1'b0;
            result           <= '0;
            io.lbist_req_rdy <= 1'b0;
            io.lfsr_resp_val <= 1'b1;
            io.lfsr_resp_msg <= seed_at('0);
            io.misr_req_val  <= 1'b1;
            io.misr_req_msg  <= HASH_COUNT;
          end
        end

        SEND: begin
          if (lfsr_xfer) begin
            lfsr_sent        <= 1'b1;
            io.lfsr_resp_val <= 1'b0;
          end
          if (misr_req_xfer) begin
            misr_sent       <= 1'b1;
            io.misr_req_val <= 1'b0;
          end
          if (lfsr_done && misr_done) begin
            state            <= WAIT;
            lfsr_sent        <= 1'b0;
            misr_sent        <= 1'b0;
            io.misr_resp_rdy <= 1'b1;
          end
        end

        WAIT: begin
          if (misr_resp_xfer) begin
            result           <= result_upd;
            io.misr_resp_rdy <= 1'b0;
            if (seed_idx == LAST_IDX) begin
              state             <= DONE;
              io.lbist_resp_val <= 1'b1;
              io.lbist_resp_msg <= result_upd;
            end else begin
              state            <= SEND;
              seed_idx         <= next_idx;
              io.lfsr_resp_val <= 1'b1;
              io.lfsr_resp_msg <= seed_at(next_idx);
              io.misr_req_val  <= 1'b1;
              io.misr_req_msg  <= HASH_COUNT;
            end
          end
        end

        DONE: begin
          if (lbist_resp_xfer) begin
            state             <= IDLE;
            io.lbist_resp_val <= 1'b0;
            io.lbist_req_rdy  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
